// File: rtl/mult16_seq_ctrl.sv
// Purpose: 16x16 unsigned multiply built from four passes through one shared external 8x8 multiplier.
// Latency: 4 cycles after accept (MUL_LAT=0), 8 (MUL_LAT=1); a zero operand completes in one cycle.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid&&out_ready.
module mult16_seq_ctrl #(
    parameter int unsigned MUL_LAT   = 0,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_en,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] product_q, product_d;
    logic        out_valid_q, out_valid_d;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [4:0]  shamt;
    logic [31:0] addend;
    logic [31:0] acc_sum;

    // Step bit 0 picks the high byte of A, bit 1 the high byte of B; the shift is the byte weight of the pair.
    always_comb begin
        op_a  = step_q[0] ? a_q[15:8] : a_q[7:0];
        op_b  = step_q[1] ? b_q[15:8] : b_q[7:0];
        shamt = 5'd0;
        unique case (step_q)
            2'd0:    shamt = 5'd0;
            2'd1:    shamt = 5'd8;
            2'd2:    shamt = 5'd8;
            default: shamt = 5'd16;
        endcase
    end

    // The step index is left unchanged between ISSUE and WAIT, so the same shift applies to the late result.
    assign addend  = {16'h0000, mul_p} << shamt;
    assign acc_sum = acc_q + addend;

    // Multiplier operands are forced to zero outside the issue cycle.
    assign mul_en    = (state_q == S_ISSUE);
    assign mul_a     = mul_en ? op_a : 8'h00;
    assign mul_b     = mul_en ? op_b : 8'h00;
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Next-state: accept, step through four partial products, then hold the result for the sink.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = 32'h0;
                    step_d = 2'd0;
                    if (ZERO_SKIP && ((a == 16'h0) || (b == 16'h0))) begin
                        product_d   = 32'h0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (MUL_LAT == 0) begin
                    acc_d = acc_sum;
                    if (step_q == 2'd3) begin
                        product_d   = acc_sum;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                acc_d = acc_sum;
                if (step_q == 2'd3) begin
                    product_d   = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight without producing a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            a_q         <= 16'h0;
            b_q         <= 16'h0;
            acc_q       <= 32'h0;
            product_q   <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
